commit_retire: RTL and testbench
================================

Name: commit_retire

Overview:
- In-order retire stage at the opposite end of the reorder/reservation buffer from dispatch. Dispatch writes entries with ascending 4-bit tags; this block reads them back.
- Each cycle it locates the oldest outstanding tags in the buffer. It retires up to two executed entries per cycle in tag order.
- Retiring an entry means writing its result to the register file, draining its store to memory, and telling the buffer to free the slot.

Parameters:
- BUF_SIZE, package value, number of buffer entries searched (shared with dispatch).
- TAG_W, 4, width of tag_t; tag arithmetic is modulo 2^TAG_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- entries[BUF_SIZE]  in  entry_t  live buffer contents (e_state, tag, Unit, Dest, result, Vk)
- reg_we[2]  out  1  register write enable, slot 0 older than slot 1
- reg_waddr[2]  out  5  destination register
- reg_wdata[2]  out  32  value written
- free_valid[2]  out  1  buffer slot release strobe
- free_index[2]  out  index_t  slot to set to S_NOT_USED
- mem_req  out  1  store write request, held until ack
- mem_addr  out  32  store address (entry result)
- mem_wdata  out  32  store data (entry Vk)
- mem_ack  in  1  store accepted this cycle
- store_retired  out  1  one-cycle pulse per completed store (decrements early-store counts)
- next_tag  out  tag_t  tag expected to retire next

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all reg_we, free_valid, mem_req and store_retired are 0; reg_waddr, reg_wdata, free_index, mem_addr, mem_wdata and next_tag are 0; FSM is in IDLE.
- Search (combinational): find the entry with tag==next_tag, and the entry with tag==next_tag+1 (wrapping 15->0), among entries whose e_state != S_NOT_USED. An entry is ready when e_state==S_EXECUTED.
- Empty buffer (every e_state==S_NOT_USED): next_tag is loaded with 0 on the next edge. This matches dispatch restarting tags at 0 on an empty buffer.
- FSM IDLE:
  - If the oldest entry is not ready, nothing retires.
  - If the oldest entry is ready and non-store, retire it. If the second entry is also ready and non-store, retire it in the same cycle.
  - If the oldest entry is ready and a store, register mem_addr/mem_wdata, assert mem_req and go to STORE_WAIT. Nothing retires that cycle.
  - A store in the second slot is never retired alongside the first; it waits to become oldest.
- FSM STORE_WAIT:
  - Hold mem_req and the registered address/data stable until mem_ack.
  - On mem_ack: deassert mem_req next edge, pulse store_retired, pulse free_valid[0] for the store's index, advance next_tag by 1, return to IDLE.
  - No register write for stores.
- Retire outputs: registered, so latency is 1 cycle from the entry appearing ready to the strobes.
  - reg_we[k] is 1 only if the retired entry has Dest != 0. A retire with Dest==0 still frees the slot.
  - next_tag advances by the number retired (0, 1 or 2), modulo 16, on the same edge the strobes assert.
- Order: when both slots retire to the same Dest, slot 1 is the younger write. The register file must apply slot 1 last; this block guarantees the slot ordering.
- No double retire: a freed entry still visible as executed in the cycle after retire is ignored, because its tag no longer matches next_tag.
- Reset mid-store: mem_req drops the cycle after reset and no store_retired is issued. A late mem_ack in IDLE is ignored.
- Branch entries retire like ALU entries (Dest normally 0). Speculative tag clearing is outside this block.

Optional Feature:
- Macro: COMMIT_DUAL_RETIRE_EN.
- Defined: two non-store retires per cycle as described above.
- Undefined: at most one retire per cycle; reg_we[1] and free_valid[1] are tied to 0; next_tag advances by 0 or 1 only.

Decomposition:
- Shared package: add commit_state_t (IDLE, STORE_WAIT). Reuse the existing entry_t, tag_t, index_t, BUF_SIZE and S_EXECUTED / S_NOT_USED / STORE enums. Add a tag_next(tag,n) function for modulo-16 increment.
- Sub-module: commit_finder (combinational). Takes entries and next_tag; returns found[2], ready[2], is_store[2] and index[2] for tags next_tag and next_tag+1.

Test Plan:
- Reset then empty buffer -> next_tag=0, all strobes 0, mem_req=0.
- Tags 0 and 1 executed ALU, Dest=5/6, results 0x11/0x22 -> next cycle reg_we={1,1}, waddr={5,6}, wdata={0x11,0x22}, free both, next_tag=2.
- Tag 2 not executed, tag 3 executed -> no retire until tag 2 executes, then 2 and 3 retire together.
- Tag 0 is a store, result=0x100, Vk=0xAB; mem_ack delayed 3 cycles -> mem_req high 4 cycles with addr/data stable; then store_retired pulse, free_valid[0], next_tag=1.
- next_tag=15, tags 15 and 0 executed -> both retire, next_tag=1 (wrap); Dest=0 entry gives reg_we=0 but free_valid=1.
- Reset asserted during STORE_WAIT -> mem_req=0 next cycle, no store_retired, subsequent mem_ack ignored.

Source files
------------

// File: rtl/commit_retire_pkg.sv
// Shared types for the reorder buffer and the in-order retire stage.
package commit_retire_pkg;

    localparam int TAG_W    = 4;
    localparam int BUF_SIZE = 8;
    localparam int IDX_W    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] index_t;

    typedef enum logic [1:0] {
        S_NOT_USED = 2'd0,
        S_ISSUED   = 2'd1,
        S_EXECUTED = 2'd2
    } e_state_t;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        BRANCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } unit_t;

    typedef struct packed {
        e_state_t    e_state;
        tag_t        tag;
        unit_t       unit;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] vk;
    } entry_t;

    typedef enum logic {
        IDLE       = 1'b0,
        STORE_WAIT = 1'b1
    } commit_state_t;

    // Tag arithmetic wraps at 2^TAG_W, matching dispatch.
    function automatic tag_t tag_next(input tag_t tag, input logic [1:0] n);
        return tag + tag_t'(n);
    endfunction

endpackage

// File: rtl/commit_finder.sv
// Locates the two oldest outstanding tags (next_tag, next_tag+1) in the buffer.
module commit_finder
    import commit_retire_pkg::*;
(
    input  entry_t entries  [BUF_SIZE],
    input  tag_t   next_tag,
    output logic   found    [2],
    output logic   ready    [2],
    output logic   is_store [2],
    output index_t index    [2],
    output entry_t slot     [2],
    output logic   empty
);

    // Tags are unique among live entries, so at most one slot matches each target.
    always_comb begin
        // NOTE: every output is defaulted before the search so no path leaves one unassigned (no latch).
        empty = 1'b1;
        for (int k = 0; k < 2; k++) begin
            found[k]    = 1'b0;
            ready[k]    = 1'b0;
            is_store[k] = 1'b0;
            index[k]    = '0;
            slot[k]     = '0;
        end
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (entries[i].e_state != S_NOT_USED) begin
                empty = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (entries[i].tag == tag_next(next_tag, 2'(k))) begin
                        found[k]    = 1'b1;
                        ready[k]    = (entries[i].e_state == S_EXECUTED);
                        is_store[k] = (entries[i].unit == STORE);
                        index[k]    = index_t'(i);
                        slot[k]     = entries[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_retire.sv
// In-order retire stage: retires executed buffer entries in tag order, writes
// results to the register file, drains stores to memory and frees slots.
// Optional COMMIT_DUAL_RETIRE_EN: allows two non-store retires per cycle;
// when undefined, at most one entry retires per cycle.
module commit_retire
    import commit_retire_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  entry_t      entries    [BUF_SIZE],
    output logic        reg_we     [2],
    output logic [4:0]  reg_waddr  [2],
    output logic [31:0] reg_wdata  [2],
    output logic        free_valid [2],
    output index_t      free_index [2],
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        store_retired,
    output tag_t        next_tag
);

    logic          found    [2];
    logic          ready    [2];
    logic          is_store [2];
    index_t        index    [2];
    entry_t        slot     [2];
    logic          empty;
    logic          retire0;
    logic          retire1;
    logic          unused_fields;
    commit_state_t state;
    index_t        store_index;

    commit_finder u_finder (
        .entries  (entries),
        .next_tag (next_tag),
        .found    (found),
        .ready    (ready),
        .is_store (is_store),
        .index    (index),
        .slot     (slot),
        .empty    (empty)
    );

    // Oldest entry retires when executed and not a store; the second only rides along.
    assign retire0 = (state == IDLE) && found[0] && ready[0] && !is_store[0];
`ifdef COMMIT_DUAL_RETIRE_EN
    assign retire1 = retire0 && found[1] && ready[1] && !is_store[1];
    assign unused_fields = ^{slot[0].e_state, slot[0].tag, slot[0].unit,
                             slot[1].e_state, slot[1].tag, slot[1].unit};
`else
    assign retire1 = 1'b0;
    assign unused_fields = ^{slot[0].e_state, slot[0].tag, slot[0].unit,
                             slot[1], found[1], ready[1], is_store[1], index[1]};
`endif

    // Retire FSM with registered strobes; one store is outstanding at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            next_tag      <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            store_retired <= 1'b0;
            store_index   <= '0;
            for (int k = 0; k < 2; k++) begin
                reg_we[k]     <= 1'b0;
                reg_waddr[k]  <= '0;
                reg_wdata[k]  <= '0;
                free_valid[k] <= 1'b0;
                free_index[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every strobe reflects pre-edge state.
            store_retired <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                reg_we[k]     <= 1'b0;
                free_valid[k] <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (empty) begin
                        // Dispatch restarts tags at 0 on an empty buffer.
                        next_tag <= '0;
                    end else if (found[0] && ready[0] && is_store[0]) begin
                        mem_req     <= 1'b1;
                        mem_addr    <= slot[0].result;
                        mem_wdata   <= slot[0].vk;
                        store_index <= index[0];
                        state       <= STORE_WAIT;
                    end else if (retire0) begin
                        reg_we[0]     <= (slot[0].dest != 5'd0);
                        reg_waddr[0]  <= slot[0].dest;
                        reg_wdata[0]  <= slot[0].result;
                        free_valid[0] <= 1'b1;
                        free_index[0] <= index[0];
                        if (retire1) begin
                            reg_we[1]     <= (slot[1].dest != 5'd0);
                            reg_waddr[1]  <= slot[1].dest;
                            reg_wdata[1]  <= slot[1].result;
                            free_valid[1] <= 1'b1;
                            free_index[1] <= index[1];
                        end
                        next_tag <= tag_next(next_tag, retire1 ? 2'd2 : 2'd1);
                    end
                end
                STORE_WAIT: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        store_retired <= 1'b1;
                        free_valid[0] <= 1'b1;
                        free_index[0] <= store_index;
                        next_tag      <= tag_next(next_tag, 2'd1);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_retire.sv
// Randomized bench for commit_retire. The bench plays the reorder buffer and
// memory: it dispatches entries with ascending tags, executes them in random
// order, frees slots one cycle after the retire strobe, and acks stores after
// a random delay. A program-order queue predicts each cycle's outputs into a
// scoreboard that an independent monitor drains and compares.
module tb_commit_retire;
    import commit_retire_pkg::*;

    localparam int N_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset;
    entry_t      entries    [BUF_SIZE];
    logic        reg_we     [2];
    logic [4:0]  reg_waddr  [2];
    logic [31:0] reg_wdata  [2];
    logic        free_valid [2];
    index_t      free_index [2];
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        store_retired;
    tag_t        next_tag;

    commit_retire dut (
        .clk           (clk),
        .reset         (reset),
        .entries       (entries),
        .reg_we        (reg_we),
        .reg_waddr     (reg_waddr),
        .reg_wdata     (reg_wdata),
        .free_valid    (free_valid),
        .free_index    (free_index),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .store_retired (store_retired),
        .next_tag      (next_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after one clock edge.
    typedef struct packed {
        logic [31:0]             cycle;
        logic                    full;
        logic [1:0]              we;
        logic [1:0][4:0]         waddr;
        logic [1:0][31:0]        wdata;
        logic [1:0]              fv;
        logic [1:0][IDX_W-1:0]   fi;
        logic                    mem_req;
        logic [31:0]             addr;
        logic [31:0]             data;
        logic                    st_ret;
        tag_t                    tag;
    } exp_t;

    exp_t sb_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Buffer / reference model state
    int          age_q [$];          // outstanding slots in program order
    int          free_at [BUF_SIZE]; // negedge cycle at which the slot is cleared
    tag_t        dispatch_tag;
    tag_t        exp_tag;
    bit          in_store;
    int          store_slot;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    int          ack_cnt;
    int          next_rst_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic bit buf_empty();
        for (int i = 0; i < BUF_SIZE; i++)
            if (entries[i].e_state != S_NOT_USED) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare(input exp_t e);
        check("next_tag", 32'(next_tag), 32'(e.tag));
        check("mem_req", 32'(mem_req), 32'(e.mem_req));
        check("store_retired", 32'(store_retired), 32'(e.st_ret));
        if (e.mem_req || e.full) begin
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.data);
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reg_we%0d", k), 32'(reg_we[k]), 32'(e.we[k]));
            check($sformatf("free_valid%0d", k), 32'(free_valid[k]), 32'(e.fv[k]));
            if (e.we[k] || e.full) begin
                check($sformatf("reg_waddr%0d", k), 32'(reg_waddr[k]), 32'(e.waddr[k]));
                check($sformatf("reg_wdata%0d", k), reg_wdata[k], e.wdata[k]);
            end
            if (e.fv[k] || e.full) begin
                check($sformatf("free_index%0d", k), 32'(free_index[k]), 32'(e.fi[k]));
            end
        end
    endtask

    task automatic clear_buffer();
        for (int i = 0; i < BUF_SIZE; i++) begin
            entries[i] = '0;
            free_at[i] = -1;
        end
        age_q.delete();
    endtask

    // Retire the oldest outstanding entry into expected-output slot k.
    task automatic retire_oldest(inout exp_t r, input int k, input int now);
        int s;
        s = age_q.pop_front();
        r.we[k]    = (entries[s].dest != 5'd0);
        r.waddr[k] = entries[s].dest;
        r.wdata[k] = entries[s].result;
        r.fv[k]    = 1'b1;
        r.fi[k]    = IDX_W'(s);
        exp_tag    = exp_tag + 1'b1;
        free_at[s] = now + 2;
    endtask

    task automatic stim_step();
        int   k;
        int   p;
        int   s;
        bit   was_empty;
        bit   ack;
        exp_t r;
        k = cyc;
        r = '0;
        r.cycle = 32'(k + 1);
        was_empty = buf_empty();

        if (k < 3 || (in_store && k >= next_rst_at)) begin
            if (k >= 3) next_rst_at = k + 400;
            reset    = 1'b1;
            mem_ack  = 1'($urandom_range(0, 1));
            clear_buffer();
            in_store     = 1'b0;
            exp_tag      = '0;
            dispatch_tag = '0;
            r.full       = 1'b1;
            sb_q.push_back(r);
            return;
        end
        reset = 1'b0;
        if (was_empty) dispatch_tag = '0;

        // Slots released by retires become free one cycle after the strobe.
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (free_at[i] == k) begin
                entries[i] = '0;
                free_at[i] = -1;
            end
        end

        // Memory handshake: delayed ack for the pending store, stray acks otherwise.
        if (in_store) begin
            ack = (ack_cnt == 0);
            if (ack_cnt > 0) ack_cnt--;
        end else begin
            ack = ($urandom_range(0, 5) == 0);
        end
        mem_ack = ack;

        // Out-of-order execution completion.
        for (int i = 0; i < BUF_SIZE; i++)
            if (entries[i].e_state == S_ISSUED && $urandom_range(0, 2) == 0)
                entries[i].e_state = S_EXECUTED;

        // Dispatch with ascending tags.
        p = (k < 1000) ? 50 : (k < 2000) ? 90 : 25;
        if ($urandom_range(0, 99) < p) begin
            s = -1;
            for (int i = BUF_SIZE - 1; i >= 0; i--)
                if (entries[i].e_state == S_NOT_USED) s = i;
            if (s >= 0) begin
                entries[s].e_state = S_ISSUED;
                entries[s].tag     = dispatch_tag;
                entries[s].result  = $urandom;
                entries[s].vk      = $urandom;
                entries[s].dest    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                case ($urandom_range(0, 7))
                    0, 1:    entries[s].unit = STORE;
                    2: begin entries[s].unit = BRANCH; entries[s].dest = 5'd0; end
                    3:       entries[s].unit = LOAD;
                    default: entries[s].unit = ALU;
                endcase
                age_q.push_back(s);
                dispatch_tag = dispatch_tag + 1'b1;
            end
        end

        // Predict what the next edge produces.
        if (in_store) begin
            if (ack) begin
                r.st_ret = 1'b1;
                r.fv[0]  = 1'b1;
                r.fi[0]  = IDX_W'(store_slot);
                exp_tag  = exp_tag + 1'b1;
                void'(age_q.pop_front());
                free_at[store_slot] = k + 2;
                in_store = 1'b0;
            end else begin
                r.mem_req = 1'b1;
                r.addr    = st_addr;
                r.data    = st_data;
            end
        end else if (buf_empty()) begin
            exp_tag = '0;
        end else if (age_q.size() > 0 && entries[age_q[0]].e_state == S_EXECUTED) begin
            s = age_q[0];
            if (entries[s].unit == STORE) begin
                in_store   = 1'b1;
                store_slot = s;
                st_addr    = entries[s].result;
                st_data    = entries[s].vk;
                ack_cnt    = $urandom_range(0, 4);
                r.mem_req  = 1'b1;
                r.addr     = st_addr;
                r.data     = st_data;
            end else begin
                retire_oldest(r, 0, k);
`ifdef COMMIT_DUAL_RETIRE_EN
                if (age_q.size() > 0 && entries[age_q[0]].e_state == S_EXECUTED &&
                    entries[age_q[0]].unit != STORE)
                    retire_oldest(r, 1, k);
`endif
            end
        end
        r.tag = exp_tag;
        sb_q.push_back(r);
    endtask

    // Monitor: compare DUT outputs against the scoreboard each cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && int'(sb_q[0].cycle) < cyc) begin
                check("sb_cycle", sb_q[0].cycle, 32'(cyc));
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && int'(sb_q[0].cycle) == cyc) begin
                e = sb_q.pop_front();
                compare(e);
            end
        end
    end

    // Stimulus: buffer, dispatcher and memory behaviour.
    initial begin : stimulus
        reset        = 1'b1;
        mem_ack      = 1'b0;
        clear_buffer();
        dispatch_tag = '0;
        exp_tag      = '0;
        in_store     = 1'b0;
        store_slot   = 0;
        st_addr      = '0;
        st_data      = '0;
        ack_cnt      = 0;
        next_rst_at  = 600;
        for (int n = 0; n < N_CYCLES; n++) begin
            @(negedge clk);
            stim_step();
        end
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
